// File: rtl/line_buffer_pkg.sv
// Shared defaults and types for the dual-write-port line assembly buffer.
package line_buffer_pkg;

    localparam int DATA_WIDTH_D      = 32;
    localparam int WORDS_PER_ENTRY_D = 16;
    localparam int NUM_ENTRIES_D     = 4;

    typedef logic [DATA_WIDTH_D-1:0]                   word_t;
    typedef logic [WORDS_PER_ENTRY_D*DATA_WIDTH_D-1:0] line_t;
    typedef logic [WORDS_PER_ENTRY_D-1:0]              mask_t;
    typedef logic [$clog2(NUM_ENTRIES_D)-1:0]          eidx_t;

endpackage

// File: rtl/line_cq_fifo.sv
// Completion-order queue of entry indices: two ordered push ports, one pop.
// An entry is only ever enqueued once, so the occupancy never exceeds DEPTH;
// the count still saturates as a guard.
module line_cq_fifo
    import line_buffer_pkg::*;
#(
    parameter  int DEPTH = NUM_ENTRIES_D,
    localparam int IDX_W = $clog2(DEPTH)
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push1,
    input  logic [IDX_W-1:0] push_idx1,
    input  logic             push2,
    input  logic [IDX_W-1:0] push_idx2,
    input  logic             pop,
    output logic             valid,
    output logic [IDX_W-1:0] head
);

    localparam int CNT_W = IDX_W + 2;

    logic [IDX_W-1:0] slot_r [DEPTH];
    logic [IDX_W-1:0] rd_r;
    logic [IDX_W-1:0] wr_r;
    logic [IDX_W-1:0] wr2_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] sum_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic             valid_r;
    logic             pop_ok_s;

    // Next occupancy: pushes minus an accepted pop, saturating at DEPTH.
    always_comb begin
        pop_ok_s = pop & valid_r;
        wr2_s    = wr_r + IDX_W'(push1);
        sum_s    = count_r + CNT_W'(push1) + CNT_W'(push2) - CNT_W'(pop_ok_s);
        if (flush) begin
            count_nxt_s = {CNT_W{1'b0}};
        end else if (sum_s > CNT_W'(DEPTH)) begin
            count_nxt_s = CNT_W'(DEPTH);
        end else begin
            count_nxt_s = sum_s;
        end
    end

    // Slot storage, pointers and occupancy; port 1 lands ahead of port 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_r[i] <= {IDX_W{1'b0}};
            end
            rd_r    <= {IDX_W{1'b0}};
            wr_r    <= {IDX_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            valid_r <= 1'b0;
        end else if (flush) begin
            rd_r    <= {IDX_W{1'b0}};
            wr_r    <= {IDX_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            valid_r <= 1'b0;
        end else begin
            if (push1) begin
                slot_r[wr_r] <= push_idx1;
            end
            if (push2) begin
                slot_r[wr2_s] <= push_idx2;
            end
            wr_r    <= wr_r + IDX_W'(push1) + IDX_W'(push2);
            rd_r    <= rd_r + IDX_W'(pop_ok_s);
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != {CNT_W{1'b0}});
        end
    end

    assign valid = valid_r;
    assign head  = slot_r[rd_r];

endmodule

// File: rtl/line_buffer_dp.sv
// Multi-entry line assembly buffer with two write ports. Entries fill word by
// word; a full entry is queued in completion order and presented whole on a
// valid/ready output. The pop frees the entry for refilling.
module line_buffer_dp
    import line_buffer_pkg::*;
#(
    parameter  int DATA_WIDTH      = DATA_WIDTH_D,
    parameter  int WORDS_PER_ENTRY = WORDS_PER_ENTRY_D,
    parameter  int NUM_ENTRIES     = NUM_ENTRIES_D,
    localparam int WIDX_W          = $clog2(WORDS_PER_ENTRY),
    localparam int EIDX_W          = $clog2(NUM_ENTRIES)
)(
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush,
    input  logic                                  w_en,
    input  logic [EIDX_W-1:0]                     entry_index,
    input  logic [WIDX_W-1:0]                     word_index,
    input  logic [DATA_WIDTH-1:0]                 w_data,
    input  logic                                  w_en2,
    input  logic [EIDX_W-1:0]                     entry_index2,
    input  logic [WIDX_W-1:0]                     word_index2,
    input  logic [DATA_WIDTH-1:0]                 w_data2,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [EIDX_W-1:0]                     out_entry,
    output logic [WORDS_PER_ENTRY*DATA_WIDTH-1:0] r_data,
    output logic                                  collision,
    output logic                                  wr_drop
);

    localparam int LINE_W = WORDS_PER_ENTRY * DATA_WIDTH;

    logic [NUM_ENTRIES-1:0] full_s;
    logic [NUM_ENTRIES-1:0] done_s;
    logic [LINE_W-1:0]      lines_s [NUM_ENTRIES];
    logic                   wr1_act_s;
    logic                   wr2_act_s;
    logic                   coll_s;
    logic                   drop_s;
    logic                   wr1_ok_s;
    logic                   wr2_ok_s;
    logic                   pop_s;
    logic                   push1_s;
    logic                   push2_s;
    logic                   valid_s;
    logic [EIDX_W-1:0]      head_s;
    logic                   collision_r;
    logic                   wr_drop_r;

    // Qualify both write ports: flush cancels, port 1 wins a same-word tie,
    // writes into a pending (full) entry are discarded.
    always_comb begin
        wr1_act_s = w_en & ~flush;
        wr2_act_s = w_en2 & ~flush;
        coll_s    = wr1_act_s & wr2_act_s & (entry_index == entry_index2)
                    & (word_index == word_index2);
        wr1_ok_s  = wr1_act_s & ~full_s[entry_index];
        wr2_ok_s  = wr2_act_s & ~coll_s & ~full_s[entry_index2];
        drop_s    = (wr1_act_s & full_s[entry_index])
                    | (wr2_act_s & ~coll_s & full_s[entry_index2]);
        pop_s     = valid_s & out_ready & ~flush;
    end

    // Enqueue entries whose mask becomes full this edge, port 1 first and a
    // jointly completed entry only once.
    always_comb begin
        push1_s = wr1_ok_s & done_s[entry_index];
        push2_s = wr2_ok_s & done_s[entry_index2]
                  & ~(wr1_ok_s & (entry_index == entry_index2));
    end

    for (genvar e = 0; e < NUM_ENTRIES; e++) begin : g_entry
        logic [WORDS_PER_ENTRY-1:0] mask_r;
        logic [WORDS_PER_ENTRY-1:0] mask_nxt_s;
        logic [WORDS_PER_ENTRY-1:0] set_s;
        logic                       hit1_s;
        logic                       hit2_s;
        logic                       clr_s;
        logic [LINE_W-1:0]          line_s;

        // Per-entry mask update: flush or pop clears, accepted writes set bits.
        always_comb begin
            hit1_s     = wr1_ok_s & (entry_index == EIDX_W'(e));
            hit2_s     = wr2_ok_s & (entry_index2 == EIDX_W'(e));
            clr_s      = flush | (pop_s & (head_s == EIDX_W'(e)));
            set_s      = (hit1_s ? ({{(WORDS_PER_ENTRY-1){1'b0}}, 1'b1} << word_index)
                                 : {WORDS_PER_ENTRY{1'b0}})
                       | (hit2_s ? ({{(WORDS_PER_ENTRY-1){1'b0}}, 1'b1} << word_index2)
                                 : {WORDS_PER_ENTRY{1'b0}});
            mask_nxt_s = clr_s ? {WORDS_PER_ENTRY{1'b0}} : (mask_r | set_s);
        end

        assign full_s[e] = &mask_r;
        assign done_s[e] = ~(&mask_r) & (&mask_nxt_s);

        // Word-valid mask register for this entry.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mask_r <= {WORDS_PER_ENTRY{1'b0}};
            end else begin
                mask_r <= mask_nxt_s;
            end
        end

        for (genvar w = 0; w < WORDS_PER_ENTRY; w++) begin : g_word
            logic [DATA_WIDTH-1:0] word_r;
            logic                  we1_s;
            logic                  we2_s;

            assign we1_s = hit1_s & (word_index == WIDX_W'(w));
            assign we2_s = hit2_s & (word_index2 == WIDX_W'(w));

            // Data word storage; contents are meaningless until the mask bit is set.
            always_ff @(posedge clk) begin
                if (we1_s) begin
                    word_r <= w_data;
                end else if (we2_s) begin
                    word_r <= w_data2;
                end
            end

            assign line_s[w*DATA_WIDTH +: DATA_WIDTH] = word_r;
        end

        assign lines_s[e] = line_s;
    end

    line_cq_fifo #(
        .DEPTH (NUM_ENTRIES)
    ) u_cq (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push1     (push1_s),
        .push_idx1 (entry_index),
        .push2     (push2_s),
        .push_idx2 (entry_index2),
        .pop       (pop_s),
        .valid     (valid_s),
        .head      (head_s)
    );

    // One-cycle status pulses for the previous edge's port conflicts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collision_r <= 1'b0;
            wr_drop_r   <= 1'b0;
        end else if (flush) begin
            collision_r <= 1'b0;
            wr_drop_r   <= 1'b0;
        end else begin
            collision_r <= coll_s;
            wr_drop_r   <= drop_s;
        end
    end

    assign out_valid = valid_s;
    assign out_entry = head_s;
    assign r_data    = lines_s[head_s];
    assign collision = collision_r;
    assign wr_drop   = wr_drop_r;

endmodule

// File: tb/tb_line_buffer_dp.sv
// Scoreboard bench for line_buffer_dp: a word-array model predicts every
// completed line and status pulse; a negedge monitor compares DUT output.
`timescale 1ns/1ps
module tb_line_buffer_dp;

    localparam int DW  = 32;
    localparam int WPE = 16;
    localparam int NE  = 4;
    localparam int EW  = 2;
    localparam int WW  = 4;
    localparam int LW  = DW * WPE;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          flush = 1'b0;
    logic          w_en = 1'b0;
    logic [EW-1:0] entry_index = '0;
    logic [WW-1:0] word_index = '0;
    logic [DW-1:0] w_data = '0;
    logic          w_en2 = 1'b0;
    logic [EW-1:0] entry_index2 = '0;
    logic [WW-1:0] word_index2 = '0;
    logic [DW-1:0] w_data2 = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [EW-1:0] out_entry;
    logic [LW-1:0] r_data;
    logic          collision;
    logic          wr_drop;

    line_buffer_dp dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .w_en(w_en), .entry_index(entry_index), .word_index(word_index), .w_data(w_data),
        .w_en2(w_en2), .entry_index2(entry_index2), .word_index2(word_index2), .w_data2(w_data2),
        .out_valid(out_valid), .out_ready(out_ready), .out_entry(out_entry),
        .r_data(r_data), .collision(collision), .wr_drop(wr_drop)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: per-entry word data and valid flags, completion order.
    logic [DW-1:0] m_data [NE][WPE];
    bit            m_vld  [NE][WPE];
    int            mq[$];
    typedef struct { int e; logic [LW-1:0] line; } exp_t;
    exp_t          sb_q[$];
    bit            exp_coll = 1'b0;
    bit            exp_drop = 1'b0;
    bit            started  = 1'b0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic bit m_full(input int e);
        for (int w = 0; w < WPE; w++) if (!m_vld[e][w]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [LW-1:0] m_line(input int e);
        logic [LW-1:0] l;
        for (int w = 0; w < WPE; w++) l[w*DW +: DW] = m_data[e][w];
        return l;
    endfunction

    task automatic model_clear();
        for (int e = 0; e < NE; e++) for (int w = 0; w < WPE; w++) m_vld[e][w] = 1'b0;
        mq.delete();
        sb_q.delete();
    endtask

    task automatic model_reset();
        model_clear();
        exp_coll = 1'b0;
        exp_drop = 1'b0;
    endtask

    // Applies one clock edge's worth of inputs to the model.
    task automatic model_apply();
        bit full_pre [NE];
        bit pushed [NE];
        int cand[$];
        int popped = -1;
        int e1, e2;
        exp_coll = 1'b0;
        exp_drop = 1'b0;
        if (flush) begin
            model_clear();
            return;
        end
        for (int e = 0; e < NE; e++) begin
            full_pre[e] = m_full(e);
            pushed[e]   = 1'b0;
        end
        if (mq.size() != 0 && out_ready) popped = mq.pop_front();
        e1 = int'(entry_index);
        e2 = int'(entry_index2);
        if (w_en) begin
            if (full_pre[e1]) exp_drop = 1'b1;
            else begin
                m_data[e1][word_index] = w_data;
                m_vld[e1][word_index]  = 1'b1;
                cand.push_back(e1);
            end
        end
        if (w_en2) begin
            if (w_en && e1 == e2 && word_index == word_index2) exp_coll = 1'b1;
            else if (full_pre[e2]) exp_drop = 1'b1;
            else begin
                m_data[e2][word_index2] = w_data2;
                m_vld[e2][word_index2]  = 1'b1;
                cand.push_back(e2);
            end
        end
        foreach (cand[i]) begin
            if (!full_pre[cand[i]] && !pushed[cand[i]] && m_full(cand[i])) begin
                pushed[cand[i]] = 1'b1;
                mq.push_back(cand[i]);
                sb_q.push_back('{cand[i], m_line(cand[i])});
            end
        end
        if (popped >= 0) for (int w = 0; w < WPE; w++) m_vld[popped][w] = 1'b0;
    endtask

    // Monitor: compares presented lines and pulses against the scoreboard.
    always @(negedge clk) begin
        if (started && rst_n) begin
            check("out_valid", LW'(out_valid), LW'(mq.size() != 0));
            check("collision", LW'(collision), LW'(exp_coll));
            check("wr_drop", LW'(wr_drop), LW'(exp_drop));
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_line: got out_valid=1 entry %0d, expected no line", out_entry);
                end else begin
                    check("out_entry", LW'(out_entry), LW'(sb_q[0].e));
                    check("r_data", r_data, sb_q[0].line);
                    if (out_ready && !flush) sb_q.delete(0);
                end
            end
        end
    end

    task automatic idle();
        w_en = 1'b0; w_en2 = 1'b0; flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_apply();
        #1;
    endtask

    task automatic wr1(input int e, input int w, input logic [DW-1:0] d);
        w_en = 1'b1; entry_index = EW'(e); word_index = WW'(w); w_data = d;
    endtask

    task automatic wr2(input int e, input int w, input logic [DW-1:0] d);
        w_en2 = 1'b1; entry_index2 = EW'(e); word_index2 = WW'(w); w_data2 = d;
    endtask

    initial begin
        idle();
        #2 rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", LW'(out_valid), LW'(0));
        check("rst_entry", LW'(out_entry), LW'(0));
        check("rst_coll", LW'(collision), LW'(0));
        check("rst_drop", LW'(wr_drop), LW'(0));
        rst_n = 1'b1;
        started = 1'b1;

        // In-order fill of entry 2 on port 1, then one pop.
        out_ready = 1'b0;
        for (int k = 0; k < WPE; k++) begin
            wr1(2, k, 32'h100 + DW'(k));
            tick();
        end
        idle();
        check("t1_valid", LW'(out_valid), LW'(1));
        check("t1_entry", LW'(out_entry), LW'(2));
        for (int k = 0; k < WPE; k++) check("t1_word", LW'(r_data[k*DW +: DW]), LW'(32'h100 + k));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t1_popped", LW'(out_valid), LW'(0));
        wr1(2, 0, 32'h0000_0777);
        tick();
        idle();
        check("t1_refill_nodrop", LW'(wr_drop), LW'(0));

        // Same word on both ports: port 1 wins.
        wr1(0, 5, 32'h0000_AAAA);
        wr2(0, 5, 32'h0000_5555);
        tick();
        idle();
        check("t2_coll_hi", LW'(collision), LW'(1));
        for (int k = 0; k < WPE; k++) begin
            if (k != 5) begin
                wr1(0, k, 32'h200 + DW'(k));
                tick();
                check("t2_coll_lo", LW'(collision), LW'(0));
            end
        end
        idle();
        check("t2_valid", LW'(out_valid), LW'(1));
        check("t2_word5", LW'(r_data[5*DW +: DW]), LW'(32'h0000_AAAA));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Two entries complete in one cycle: port 1's entry first.
        for (int k = 0; k < WPE; k++) begin
            wr1(1, k, 32'h1000 + DW'(k));
            wr2(3, k, 32'h3000 + DW'(k));
            tick();
        end
        idle();
        check("t3_first", LW'(out_entry), LW'(1));
        out_ready = 1'b1;
        tick();
        check("t3_second_valid", LW'(out_valid), LW'(1));
        check("t3_second", LW'(out_entry), LW'(3));
        tick();
        check("t3_empty", LW'(out_valid), LW'(0));
        out_ready = 1'b0;

        // Writes into a pending entry are dropped, including in the pop cycle.
        for (int k = 0; k < WPE; k++) begin
            wr1(0, k, 32'h300 + DW'(k));
            tick();
        end
        wr1(0, 3, 32'h0000_DEAD);
        tick();
        idle();
        check("t4_drop", LW'(wr_drop), LW'(1));
        check("t4_word3", LW'(r_data[3*DW +: DW]), LW'(32'h303));
        tick();
        check("t4_drop_lo", LW'(wr_drop), LW'(0));
        out_ready = 1'b1;
        wr2(0, 4, 32'h0000_BEEF);
        tick();
        idle();
        out_ready = 1'b0;
        check("t4_pop_drop", LW'(wr_drop), LW'(1));
        wr1(0, 3, 32'h0000_DEAD);
        tick();
        idle();
        check("t4_accept", LW'(wr_drop), LW'(0));

        // Flush restarts a partial line and suppresses pulses.
        for (int k = 0; k < 8; k++) begin
            wr1(1, k, 32'h500 + DW'(k));
            tick();
        end
        flush = 1'b1;
        wr1(1, 2, 32'h1);
        wr2(1, 2, 32'h2);
        tick();
        idle();
        check("t5_flush_coll", LW'(collision), LW'(0));
        for (int k = 8; k < WPE; k++) begin
            wr1(1, k, 32'h600 + DW'(k));
            tick();
        end
        idle();
        check("t5_no_complete", LW'(out_valid), LW'(0));
        for (int k = 0; k < WPE; k++) begin
            wr1(1, k, 32'h700 + DW'(k));
            tick();
        end
        idle();
        check("t5_complete", LW'(out_valid), LW'(1));
        check("t5_entry", LW'(out_entry), LW'(1));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            w_en         = ($urandom_range(0, 9) < 7);
            entry_index  = EW'($urandom_range(0, NE - 1));
            word_index   = WW'($urandom_range(0, WPE - 1));
            w_data       = $urandom();
            w_en2        = ($urandom_range(0, 9) < 7);
            entry_index2 = EW'($urandom_range(0, NE - 1));
            word_index2  = WW'($urandom_range(0, WPE - 1));
            w_data2      = $urandom();
            if ($urandom_range(0, 15) == 0) begin
                entry_index2 = entry_index;
                word_index2  = word_index;
            end
            out_ready = ($urandom_range(0, 1) == 1);
            flush     = ($urandom_range(0, 299) == 0);
            tick();
        end
        idle();
        out_ready = 1'b0;

        // Asynchronous reset while a line is presented and collision is high.
        flush = 1'b1;
        tick();
        idle();
        for (int k = 0; k < WPE - 1; k++) begin
            wr1(2, k, 32'h900 + DW'(k));
            tick();
        end
        wr1(2, 15, 32'h90F);
        wr2(2, 15, 32'h123);
        tick();
        idle();
        check("t6_valid_pre", LW'(out_valid), LW'(1));
        check("t6_coll_pre", LW'(collision), LW'(1));
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_valid_rst", LW'(out_valid), LW'(0));
        check("t6_coll_rst", LW'(collision), LW'(0));
        check("t6_drop_rst", LW'(wr_drop), LW'(0));
        check("t6_entry_rst", LW'(out_entry), LW'(0));
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("t6_valid_post", LW'(out_valid), LW'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/line_buffer_dp.md
Name: line_buffer_dp

Overview:
- Multi-entry, dual-write-port line assembly buffer for the compression Stage1 datapath; generalises the single-entry dual-port word register file.
- Two producers write 32-bit words into any word of any entry; per-word valid masks track fill state.
- Each completed line is queued in completion order and presented on a valid/ready output carrying the full line; the handshake frees the entry.

Parameters:
- DATA_WIDTH, 32, bits per word
- WORDS_PER_ENTRY, 16, words per line; power of two, >= 2
- NUM_ENTRIES, 4, number of lines; power of two, >= 2
- Derived: WIDX_W = $clog2(WORDS_PER_ENTRY), EIDX_W = $clog2(NUM_ENTRIES)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of all masks and the queue
- w_en  in  1  port-1 write enable
- entry_index  in  EIDX_W  port-1 target entry
- word_index  in  WIDX_W  port-1 target word
- w_data  in  DATA_WIDTH  port-1 data
- w_en2  in  1  port-2 write enable
- entry_index2  in  EIDX_W  port-2 target entry
- word_index2  in  WIDX_W  port-2 target word
- w_data2  in  DATA_WIDTH  port-2 data
- out_valid  out  1  a completed line is available
- out_ready  in  1  consumer accepts the line
- out_entry  out  EIDX_W  entry index of the presented line
- r_data  out  WORDS_PER_ENTRY*DATA_WIDTH  presented line; word 0 in the LSBs
- collision  out  1  registered pulse: both ports targeted the same entry and word in the same cycle
- wr_drop  out  1  registered pulse: a write targeted a pending (complete, not yet popped) entry and was discarded

Behaviour:
- Reset (rst_n=0, async): all masks 0; queue empty; out_valid=0; out_entry=0; collision=0; wr_drop=0. Word storage is not reset; r_data is don't-care while out_valid=0.
- Entry states:
  - FILLING: mask not all ones; this includes empty.
  - PENDING: mask all ones, entry is in the queue.
- Writes:
  - A write to a FILLING entry stores the data and sets the mask bit at the clock edge.
  - A rewrite of an already-valid word overwrites the data; the mask is unchanged.
- Same entry and word on both ports in one cycle: port 1 wins, port 2 is discarded, and collision=1 on the next cycle.
- Writes to a PENDING entry are discarded; wr_drop=1 on the next cycle. A write in the same cycle the entry is popped is also discarded.
- Completion:
  - When the post-write mask of an entry becomes all ones, its index is pushed to the completion FIFO at that edge.
  - Queue depth is NUM_ENTRIES. It cannot overflow, because each entry is enqueued at most once.
  - If two entries complete in one cycle, port 1's entry is pushed first.
  - If the two ports complete the same entry together, it is pushed once.
- Output:
  - out_valid = queue not empty.
  - out_entry = queue head.
  - r_data = combinational read of the head entry's storage.
  - Latency: the edge that writes the last word makes out_valid=1 in the following cycle.
- Pop: on out_valid && out_ready at an edge:
  - the head is dequeued;
  - the entry's mask clears to 0 (state FILLING);
  - the next head, if any, is presented the next cycle.
  - Back-to-back pops are allowed, one per cycle.
- While out_valid=1, r_data and out_entry hold stable until the pop.
- flush (synchronous, highest priority):
  - masks and queue clear at the edge;
  - writes and the pop in that cycle are ignored;
  - no collision or wr_drop pulse is produced for that cycle.
- Reset asserted mid-fill or mid-handshake: immediate return to the reset state; partial lines are lost.

Decomposition:
- Package line_buffer_pkg:
  - default constants DATA_WIDTH_D, WORDS_PER_ENTRY_D, NUM_ENTRIES_D;
  - typedefs word_t, line_t, mask_t (WORDS_PER_ENTRY bits), eidx_t.
- One sub-module, line_cq_fifo:
  - small index FIFO with two push ports (ordered) and one pop;
  - count saturates at NUM_ENTRIES;
  - asynchronous active-low reset and synchronous flush.
- Storage and masks stay in the top level as a generate loop over entries and words.

Test Plan:
- Reset then fill entry 2 in order, one word per cycle on port 1 (data 0x100+k, k=0..15), out_ready=0 → out_valid rises the cycle after word 15 with out_entry=2 and r_data word k=0x100+k; raise out_ready → one pop, out_valid=0 next cycle, mask of entry 2 = 0.
- Same entry 0, word 5, on both ports (0xAAAA on port 1, 0x5555 on port 2), then complete the line → collision=1 for exactly one cycle; word 5 reads 0xAAAA.
- Port 1 finishes entry 1 and port 2 finishes entry 3 in the same cycle → pops return out_entry 1 then 3 in consecutive cycles with out_ready held high.
- Entry 0 pending, out_ready=0; write entry 0 word 3 with 0xDEAD → wr_drop=1 for one cycle, word 3 unchanged; after the pop, entry 0 accepts the write normally.
- Fill 8 words of entry 1, assert flush for one cycle, then write 8 more words → no completion (mask restarted); a full 16-word refill then completes.
- Assert rst_n=0 asynchronously while out_valid=1 → out_valid drops before the next clock edge, queue empty, collision and wr_drop both 0.
